ps2_kbd_rx: RTL

PS/2 keyboard receiver that sits directly upstream of the board top level: it turns the raw `ps2_clk`/`ps2_data` pins into checked scan-code bytes in an 8-entry FIFO. It also tracks the currently held key and counts fresh key presses for the seven-segment and LED displays. Everything runs in the system `clk` domain. The PS/2 lines are treated as asynchronous inputs.

---
 rtl/ps2_kbd_rx_if.sv | 11 +
 rtl/ps2_kbd_rx.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_rx_if.sv
// FIFO-side bus of the PS/2 keyboard receiver: pop handshake, head byte and status flags.
interface ps2_kbd_rx_if;
  logic       rd_en;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  modport master (input rd_en, output data, ready, overflow, frame_err);
  modport slave  (output rd_en, input data, ready, overflow, frame_err);
endinterface

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronizes the PS/2 pins, checks 11-bit frames, queues bytes
// in a small FIFO and tracks the currently held key for the display logic.
module ps2_kbd_rx #(
  parameter int FIFO_AW = 3,
  parameter int TIMEOUT = 5000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ps2_clk,
  input  logic         ps2_data,
  ps2_kbd_rx_if.master bus,
  output logic [7:0]   cur_key,
  output logic         key_ext,
  output logic         key_down,
  output logic [7:0]   press_count
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int IW    = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} trk_state_t;

  logic [2:0]         clk_sync, data_sync;
  logic               fall, bit_in, last, frame_ok, wr;
  logic [3:0]         bit_cnt;
  logic [IW-1:0]      idle_cnt;
  logic [9:0]         shreg;
  logic [7:0]         rx_byte;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wp, rp;
  logic [FIFO_AW:0]   cnt;
  logic               full, pop, push;
  trk_state_t         state, state_nxt;
  logic               is_make, is_brk, ext_flag, same_key;

  // Stage 0: synchronizers and edge detect; [2] is the older stage.
  assign fall     = clk_sync[2] & ~clk_sync[1];
  assign bit_in   = data_sync[1];
  assign last     = fall && (bit_cnt == 4'd10);
  assign rx_byte  = shreg[8:1];
  assign frame_ok = ~shreg[0] & bit_in & (^shreg[9:1]);
  assign wr       = last & frame_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync      <= 3'b111;
      data_sync     <= 3'b111;
      bit_cnt       <= 4'd0;
      idle_cnt      <= '0;
      bus.frame_err <= 1'b0;
    end else begin
      clk_sync      <= {clk_sync[1:0], ps2_clk};
      data_sync     <= {data_sync[1:0], ps2_data};
      bus.frame_err <= last & ~frame_ok;
      if (fall) begin
        idle_cnt <= '0;
        bit_cnt  <= (bit_cnt == 4'd10) ? 4'd0 : bit_cnt + 4'd1;
      end else begin
        if (idle_cnt != IW'(TIMEOUT))
          idle_cnt <= idle_cnt + IW'(1);
        if (bit_cnt != 4'd0 && idle_cnt == IW'(TIMEOUT))
          bit_cnt <= 4'd0;
      end
    end
  end

  // Bits shift in from the top so the start bit lands in shreg[0] after ten edges.
  always_ff @(posedge clk) begin
    if (fall)
      shreg <= {bit_in, shreg[9:1]};
  end

  // Stage 1: FIFO; a pop in the same cycle frees the slot for a write into a full FIFO.
  assign pop  = bus.rd_en && (cnt != '0);
  assign full = (cnt == (FIFO_AW+1)'(DEPTH));
  assign push = wr && (!full || pop);

  always_ff @(posedge clk) begin
    if (push)
      mem[wp] <= rx_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp           <= '0;
      rp           <= '0;
      cnt          <= '0;
      bus.overflow <= 1'b0;
    end else begin
      if (push)
        wp <= wp + FIFO_AW'(1);
      if (pop)
        rp <= rp + FIFO_AW'(1);
      cnt <= cnt + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
      if (wr && !push)
        bus.overflow <= 1'b1;
      else if (pop)
        bus.overflow <= 1'b0;
    end
  end

  assign bus.ready = (cnt != '0);
  assign bus.data  = bus.ready ? mem[rp] : 8'h00;

  // Stage 1: key tracker, fed with every accepted byte.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    is_make   = 1'b0;
    is_brk    = 1'b0;
    ext_flag  = 1'b0;
    if (wr) begin
      case (state)
        IDLE: begin
          if (rx_byte == 8'hE0)      state_nxt = EXT;
          else if (rx_byte == 8'hF0) state_nxt = BRK;
          else                       is_make   = 1'b1;
        end
        EXT: begin
          if (rx_byte == 8'hF0) state_nxt = EXT_BRK;
          else begin
            is_make   = 1'b1;
            ext_flag  = 1'b1;
            state_nxt = IDLE;
          end
        end
        BRK: begin
          is_brk    = 1'b1;
          state_nxt = IDLE;
        end
        EXT_BRK: begin
          is_brk    = 1'b1;
          ext_flag  = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign same_key = (rx_byte == cur_key) && (ext_flag == key_ext);

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_key     <= 8'h00;
      key_ext     <= 1'b0;
      key_down    <= 1'b0;
      press_count <= 8'h00;
    end else if (is_make && !(key_down && same_key)) begin
      cur_key     <= rx_byte;
      key_ext     <= ext_flag;
      key_down    <= 1'b1;
      press_count <= press_count + 8'd1;
    end else if (is_brk && same_key) begin
      cur_key  <= 8'h00;
      key_ext  <= 1'b0;
      key_down <= 1'b0;
    end
  end
endmodule
